lc3_alu_sequencer: RTL and testbench

LC3_ALU_SEQUENCER -- requirements
Module: lc3_alu_sequencer

---
 rtl/lc3_alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_lc3_alu_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_alu_sequencer.sv
// Multi-cycle sequencer for the LC-3 operate instructions ADD, AND and NOT.
// It steps through IDLE, DECODE, EXEC and WRITE against an external register file that has one cycle of read latency.
module lc3_alu_sequencer #(
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rf_rd_addr_a,
  output logic [2:0]  rf_rd_addr_b,
  input  logic [15:0] rf_rd_data_a,
  input  logic [15:0] rf_rd_data_b,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WRITE,
    FAULT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  state_t      state;
  logic [15:0] instr_q;
  logic        ready_q;
  logic [15:0] imm5_sext;
  logic [15:0] operand_b;
  logic [15:0] alu_result;
  logic        opcode_legal;
  logic [2:0]  result_nzp;

  // Ready is gated by rst_n so it drops the instant reset asserts and is
  // high again straight after release, allowing an accept on the first edge.
  assign instr_ready = ready_q & rst_n;

  always_comb begin
    imm5_sext  = {{11{instr_q[4]}}, instr_q[4:0]};
    operand_b  = instr_q[5] ? imm5_sext : rf_rd_data_b;
    alu_result = '0;
    opcode_legal = 1'b0;
    case (instr_q[15:12])
      OP_ADD: begin
        alu_result   = rf_rd_data_a + operand_b;
        opcode_legal = 1'b1;
      end
      OP_AND: begin
        alu_result   = rf_rd_data_a & operand_b;
        opcode_legal = 1'b1;
      end
      OP_NOT: begin
        alu_result   = ~rf_rd_data_a;
        opcode_legal = 1'b1;
      end
      default: begin
        alu_result   = '0;
        opcode_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    if (alu_result[15])
      result_nzp = 3'b100;
    else if (alu_result == 16'h0000)
      result_nzp = 3'b010;
    else
      result_nzp = 3'b001;
  end

  // Every output is registered.  The strobes default low each cycle, which keeps each of them to a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_q      <= '0;
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      nzp          <= NZP_RESET;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && ready_q) begin
            instr_q      <= instr;
            rf_rd_addr_a <= instr[8:6];
            rf_rd_addr_b <= instr[2:0];
            ready_q      <= 1'b0;
            busy         <= 1'b1;
            state        <= DECODE;
          end
        end
        DECODE: begin
          if (opcode_legal) begin
            rf_rd_addr_a <= instr_q[8:6];
            rf_rd_addr_b <= instr_q[2:0];
            state        <= EXEC;
          end else begin
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
            illegal      <= 1'b1;
            state        <= FAULT;
          end
        end
        EXEC: begin
          rf_rd_addr_a <= '0;
          rf_rd_addr_b <= '0;
          rf_wr_en     <= 1'b1;
          rf_wr_addr   <= instr_q[11:9];
          rf_wr_data   <= alu_result;
          nzp          <= result_nzp;
          done         <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          rf_wr_addr <= '0;
          rf_wr_data <= '0;
          ready_q    <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        FAULT: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          rf_rd_addr_a <= '0;
          rf_rd_addr_b <= '0;
          ready_q      <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Self-checking bench for lc3_alu_sequencer: a register-file model, an instruction-level reference model
// compared every cycle, directed literal cases and a randomized instruction stream.
module tb_lc3_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_rd_addr_a;
  logic [2:0]  rf_rd_addr_b;
  logic [15:0] rf_rd_data_a;
  logic [15:0] rf_rd_data_b;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;
  logic        busy;

  lc3_alu_sequencer #(.NZP_RESET(3'b010)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_rd_addr_a(rf_rd_addr_a),
    .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a),
    .rf_rd_data_b(rf_rd_data_b),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .nzp         (nzp),
    .done        (done),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_reg(input int i);
    case (i)
      0: return 16'h1234;
      1: return 16'h0005;
      2: return 16'hFFFB;
      3: return 16'h0005;
      4: return 16'hF0F3;
      5: return 16'h0001;
      6: return 16'h8000;
      default: return 16'h000F;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] r);
    if (r[15]) return 3'b100;
    if (r == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  // Register file model with one cycle of read latency; a write lands at the edge that ends the write cycle.
  logic [15:0] rf [8];
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = init_reg(i);
    rf_rd_data_a = '0;
    rf_rd_data_b = '0;
    forever begin
      @(posedge clk);
      rf_rd_data_a <= rf[rf_rd_addr_a];
      rf_rd_data_b <= rf[rf_rd_addr_b];
      if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic last_hs;

  logic [15:0] mregs [8];
  logic [2:0]  mnzp;
  bit          active;
  int          age;
  bit          m_legal;
  logic [15:0] m_res;
  logic [15:0] m_instr;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Architectural effect of one instruction: result and whether it is supported.
  task automatic predict(input logic [15:0] w, output bit legal, output logic [15:0] res);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    imm = {{11{w[4]}}, w[4:0]};
    a = mregs[w[8:6]];
    b = w[5] ? imm : mregs[w[2:0]];
    legal = 1'b1;
    case (w[15:12])
      4'b0001: res = a + b;
      4'b0101: res = a & b;
      4'b1001: res = ~a;
      default: begin res = '0; legal = 1'b0; end
    endcase
  endtask

  // One clock: note the handshake for this cycle, advance to mid-next-cycle, then compare every output against the model.
  task automatic tick();
    logic        hs;
    logic [15:0] w;
    logic        e_wr;
    logic        e_ill;
    logic [2:0]  e_ra;
    logic [2:0]  e_rb;
    hs = instr_valid && instr_ready;
    w  = instr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    last_hs = hs;
    if (!rst_n) begin
      active = 0;
      mnzp   = 3'b010;
      check("reset_busy", 16'(busy), 16'h0);
      check("reset_ready", 16'(instr_ready), 16'h0);
      check("reset_wr_en", 16'(rf_wr_en), 16'h0);
      check("reset_done", 16'(done), 16'h0);
      check("reset_illegal", 16'(illegal), 16'h0);
      check("reset_rd_a", 16'(rf_rd_addr_a), 16'h0);
      check("reset_rd_b", 16'(rf_rd_addr_b), 16'h0);
      check("reset_wr_addr", 16'(rf_wr_addr), 16'h0);
      check("reset_wr_data", rf_wr_data, 16'h0);
      check("reset_nzp", 16'(nzp), 16'(mnzp));
    end else begin
      if (active) begin
        age++;
        if ((m_legal && age == 4) || (!m_legal && age == 3)) active = 0;
      end
      if (hs) begin
        active  = 1;
        age     = 1;
        m_instr = w;
        predict(w, m_legal, m_res);
      end
      e_wr  = active && m_legal && age == 3;
      e_ill = active && !m_legal && age == 2;
      if (e_wr) begin
        mnzp = nzp_of(m_res);
        mregs[m_instr[11:9]] = m_res;
      end
      if (active && (age == 1 || (age == 2 && m_legal))) begin
        e_ra = m_instr[8:6];
        e_rb = m_instr[2:0];
      end else begin
        e_ra = 3'b000;
        e_rb = 3'b000;
      end
      check("busy", 16'(busy), 16'(active));
      check("instr_ready", 16'(instr_ready), 16'(!active));
      check("wr_en", 16'(rf_wr_en), 16'(e_wr));
      check("done", 16'(done), 16'(e_wr));
      check("illegal", 16'(illegal), 16'(e_ill));
      check("rd_addr_a", 16'(rf_rd_addr_a), 16'(e_ra));
      check("rd_addr_b", 16'(rf_rd_addr_b), 16'(e_rb));
      check("nzp", 16'(nzp), 16'(mnzp));
      if (e_wr) begin
        check("wr_addr", 16'(rf_wr_addr), 16'(m_instr[11:9]));
        check("wr_data", rf_wr_data, m_res);
      end
    end
  endtask

  // Offer an instruction and hold it until accepted; returns mid-cycle T+1.
  task automatic send(input logic [15:0] w, output int acc);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) check("accept_timeout", 16'(instr_ready), 16'h1);
    acc = cyc;
    tick();
    instr_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [3:0]  op;
    int sel;
    w = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel <= 2) op = 4'b0001;
    else if (sel <= 5) op = 4'b0101;
    else if (sel <= 7) op = 4'b1001;
    else begin
      op = 4'($urandom_range(0, 15));
      while (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) op = 4'($urandom_range(0, 15));
    end
    w[15:12] = op;
    return w;
  endfunction

  initial begin
    int acc1;
    int acc2;
    for (int i = 0; i < 8; i++) mregs[i] = init_reg(i);
    mnzp = 3'b010;
    active = 0;
    age = 0;
    m_legal = 0;
    m_res = '0;
    m_instr = '0;
    last_hs = 0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;

    @(negedge clk);
    check("init_busy", 16'(busy), 16'h0);
    check("init_ready_in_reset", 16'(instr_ready), 16'h0);
    check("init_nzp", 16'(nzp), 16'h2);
    tick();
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 16'(instr_ready), 16'h1);

    // ADD with a different instruction held on the bus while busy.
    send(16'h16C2, acc1);
    instr_valid = 1'b1;
    instr = 16'h0E05;
    check("held_ready_low", 16'(instr_ready), 16'h0);
    tick();
    check("held_no_illegal", 16'(illegal), 16'h0);
    tick();
    check("add_zero_wr_en", 16'(rf_wr_en), 16'h1);
    check("add_zero_addr", 16'(rf_wr_addr), 16'h3);
    check("add_zero_data", rf_wr_data, 16'h0000);
    check("add_zero_nzp", 16'(nzp), 16'h2);
    check("add_zero_done", 16'(done), 16'h1);
    instr_valid = 1'b0;
    tick();
    check("add_zero_ready", 16'(instr_ready), 16'h1);

    // Load 0x8000 into R1, then decrement it through the immediate form.
    send(16'h13A0, acc1);
    tick();
    tick();
    check("mov_data", rf_wr_data, 16'h8000);
    tick();
    send(16'h127F, acc1);
    check("dec_rd_a_decode", 16'(rf_rd_addr_a), 16'h1);
    tick();
    check("dec_rd_a_exec", 16'(rf_rd_addr_a), 16'h1);
    tick();
    check("dec_data", rf_wr_data, 16'h7FFF);
    check("dec_addr", 16'(rf_wr_addr), 16'h1);
    check("dec_nzp", 16'(nzp), 16'h1);
    tick();

    // Back-to-back AND then NOT.
    send(16'h510F, acc1);
    tick();
    tick();
    check("and_data", rf_wr_data, 16'h0003);
    send(16'h943F, acc2);
    check("b2b_accept_gap", 16'(acc2 - acc1), 16'd4);
    tick();
    tick();
    check("not_wr_en", 16'(rf_wr_en), 16'h1);
    check("not_data", rf_wr_data, 16'hFFFC);
    check("not_nzp", 16'(nzp), 16'h4);
    check("not_cycle", 16'(cyc - acc1), 16'd7);
    tick();

    // Unsupported opcode.
    send(16'h0E05, acc1);
    tick();
    check("br_illegal", 16'(illegal), 16'h1);
    check("br_no_wr", 16'(rf_wr_en), 16'h0);
    check("br_nzp_kept", 16'(nzp), 16'h4);
    tick();
    check("br_ready", 16'(instr_ready), 16'h1);

    // Reset asserted during EXEC aborts the instruction.
    send(16'h1B61, acc1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_now", 16'(busy), 16'h0);
    check("rst_ready_now", 16'(instr_ready), 16'h0);
    check("rst_wr_en_now", 16'(rf_wr_en), 16'h0);
    check("rst_nzp_now", 16'(nzp), 16'h2);
    check("rst_rd_a_now", 16'(rf_rd_addr_a), 16'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Randomized stream with random gaps and back-to-back offers.
    for (int i = 0; i < 2500; i++) begin
      if (!instr_valid && $urandom_range(0, 2) == 0) begin
        instr_valid = 1'b1;
        instr = rand_instr();
      end
      tick();
      if (last_hs) begin
        instr_valid = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          instr_valid = 1'b1;
          instr = rand_instr();
        end
      end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
